// File: rtl/axi_hdr_pkg.sv
// Shared types and helpers for the AXI-Stream header arbiter.
// Widths, FSM state encoding and the header format check.
package axi_hdr_pkg;

    localparam int DATA_WD_DEF = 32;
    localparam int NUM_REQ_DEF = 4;
    localparam int KEEP_MAX    = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_EOP = 2'd2
    } state_t;

    // Keep must be right-aligned contiguous ones and match the byte count.
    function automatic logic hdr_fmt_ok(
        input logic [KEEP_MAX-1:0] keep,
        input int                  cnt,
        input int                  nbytes
    );
        logic                ok;
        logic [KEEP_MAX-1:0] mask;
        ok = 1'b0;
        for (int k = 1; k <= KEEP_MAX; k++) begin
            mask = (k == KEEP_MAX) ? '1
                 : ((KEEP_MAX'(1) << k) - KEEP_MAX'(1));
            if (k <= nbytes && keep == mask && cnt == k)
                ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/axi_stream_header_arbiter_if.sv
// Requester, insert-port and snooped output signals of the arbiter.
// master is the arbiter view, slave is the surrounding system.
interface axi_stream_header_arbiter_if
    import axi_hdr_pkg::*;
#(
    parameter int DATA_WD = DATA_WD_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF
);
    localparam int DATA_BYTE_WD = DATA_WD / 8;
    localparam int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);
    localparam int ID_WD        = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                   req_valid;
    logic [NUM_REQ*DATA_WD-1:0]           req_data;
    logic [NUM_REQ*DATA_BYTE_WD-1:0]      req_keep;
    logic [NUM_REQ*(BYTE_CNT_WD+1)-1:0]   req_byte_cnt;
    logic [NUM_REQ-1:0]                   req_ready;
    logic                                 valid_insert;
    logic [DATA_WD-1:0]                   data_insert;
    logic [DATA_BYTE_WD-1:0]              keep_insert;
    logic [BYTE_CNT_WD:0]                 byte_insert_cnt;
    logic                                 ready_insert;
    logic                                 mon_valid_out;
    logic                                 mon_ready_out;
    logic                                 mon_last_out;
    logic [ID_WD-1:0]                     grant_id;
    logic                                 busy;
    logic                                 hdr_err;

    modport master (
        input  req_valid, req_data, req_keep, req_byte_cnt,
        input  ready_insert,
        input  mon_valid_out, mon_ready_out, mon_last_out,
        output req_ready,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output grant_id, busy, hdr_err
    );

    modport slave (
        output req_valid, req_data, req_keep, req_byte_cnt,
        output ready_insert,
        output mon_valid_out, mon_ready_out, mon_last_out,
        input  req_ready,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  grant_id, busy, hdr_err
    );

endinterface

// File: rtl/axi_stream_header_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr.
// Produces a one-hot grant and its binary index.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    logic           w_found;
    logic [IDW-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = IDW'((int'(ptr) + i) % N);
            if (!w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_id     = w_idx;
            end
        end
    end

endmodule

// File: rtl/axi_stream_header_arbiter.sv
// Round-robin header arbiter in front of the header-insert port.
// Holds the grant from header handoff until the packet's last beat.
module axi_stream_header_arbiter
    import axi_hdr_pkg::*;
#(
    parameter int DATA_WD = DATA_WD_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    axi_stream_header_arbiter_if.master  bus
);

    localparam int DATA_BYTE_WD = DATA_WD / 8;
    localparam int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);
    localparam int CNT_WD       = BYTE_CNT_WD + 1;
    localparam int ID_WD        = $clog2(NUM_REQ);

    state_t                  r_state;
    state_t                  w_next;
    logic [ID_WD-1:0]        r_ptr;
    logic [ID_WD-1:0]        r_gnt_id;
    logic [DATA_WD-1:0]      r_data;
    logic [DATA_BYTE_WD-1:0] r_keep;
    logic [CNT_WD-1:0]       r_cnt;
    logic                    r_hdr_err;

    logic [NUM_REQ-1:0]      w_gnt;
    logic [ID_WD-1:0]        w_win_id;
    logic [ID_WD-1:0]        w_win_nxt;
    logic [ID_WD-1:0]        w_own_nxt;
    logic [DATA_WD-1:0]      w_sel_data;
    logic [DATA_BYTE_WD-1:0] w_sel_keep;
    logic [CNT_WD-1:0]       w_sel_cnt;
    logic                    w_any;
    logic                    w_ok;
    logic                    w_eop;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_WD)
    ) u_rr (
        .req    (bus.req_valid),
        .ptr    (r_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_win_id)
    );

    always_comb begin
        w_sel_data = '0;
        w_sel_keep = '0;
        w_sel_cnt  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_id == ID_WD'(i)) begin
                w_sel_data = bus.req_data[i*DATA_WD +: DATA_WD];
                w_sel_keep = bus.req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                w_sel_cnt  = bus.req_byte_cnt[i*CNT_WD +: CNT_WD];
            end
        end
    end

    assign w_any = |bus.req_valid;
    assign w_ok  = hdr_fmt_ok(KEEP_MAX'(w_sel_keep),
                              int'(w_sel_cnt), DATA_BYTE_WD);
    assign w_eop = bus.mon_valid_out & bus.mon_ready_out
                 & bus.mon_last_out;

    // Pointer moves past the requester just served so it drops to lowest.
    assign w_win_nxt = (w_win_id == ID_WD'(NUM_REQ - 1))
                     ? '0 : w_win_id + 1'b1;
    assign w_own_nxt = (r_gnt_id == ID_WD'(NUM_REQ - 1))
                     ? '0 : r_gnt_id + 1'b1;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (w_any && w_ok)    w_next = SEND;
            SEND:     if (bus.ready_insert) w_next = WAIT_EOP;
            WAIT_EOP: if (w_eop)            w_next = IDLE;
            default:                        w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_gnt_id  <= '0;
            r_data    <= '0;
            r_keep    <= '0;
            r_cnt     <= '0;
            r_hdr_err <= 1'b0;
        end else begin
            r_hdr_err <= 1'b0;
            if (r_state == IDLE && w_any) begin
                if (w_ok) begin
                    r_data   <= w_sel_data;
                    r_keep   <= w_sel_keep;
                    r_cnt    <= w_sel_cnt;
                    r_gnt_id <= w_win_id;
                end else begin
                    r_hdr_err <= 1'b1;
                    r_ptr     <= w_win_nxt;
                end
            end else if (r_state == WAIT_EOP && w_eop) begin
                r_ptr <= w_own_nxt;
            end
        end
    end

    assign bus.req_ready       = (r_state == IDLE && rst_n) ? w_gnt : '0;
    assign bus.valid_insert    = (r_state == SEND);
    assign bus.busy            = (r_state != IDLE);
    assign bus.data_insert     = r_data;
    assign bus.keep_insert     = r_keep;
    assign bus.byte_insert_cnt = r_cnt;
    assign bus.grant_id        = r_gnt_id;
    assign bus.hdr_err         = r_hdr_err;

endmodule
